// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder for the DE1-SoC lab processor bus: LEDR/HEX
// registers, synchronized SW readback and KEY[2:0] press capture over req/ack.
module io_bus_responder #(
   parameter int A_W         = 16,
   parameter int D_W         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic           Clock,
   input  logic           Resetn,
   input  logic           req,
   input  logic           wr,
   input  logic [A_W-1:0] addr,
   input  logic [D_W-1:0] wdata,
   output logic           ack,
   output logic [D_W-1:0] rdata,
   input  logic [9:0]     SW,
   input  logic [2:0]     KEY,
   output logic [9:0]     LEDR,
   output logic [6:0]     HEX0,
   output logic [6:0]     HEX1,
   output logic [6:0]     HEX2,
   output logic [6:0]     HEX3,
   output logic [6:0]     HEX4,
   output logic [6:0]     HEX5
);

   typedef enum logic {IDLE, ACK} state_t;

   state_t         state_q, state_d;
   logic [D_W-1:0] rdata_q, rdata_d;
   logic [9:0]     led_q, led_d;
   logic [6:0]     hex_q [6];
   logic [6:0]     hex_d [6];
   logic [2:0]     cap_q, cap_d;
   logic [2:0]     key_prev_q;
   logic [9:0]     sw_sync_q  [SYNC_STAGES];
   logic [2:0]     key_sync_q [SYNC_STAGES];
   logic [9:0]     sw_s;
   logic [2:0]     key_s;
   logic [2:0]     press;
   logic [2:0]     clr;
   logic [3:0]     sel;
   logic           unused_bits;

   assign sw_s        = sw_sync_q[SYNC_STAGES-1];
   assign key_s       = key_sync_q[SYNC_STAGES-1];
   assign press       = key_prev_q & ~key_s;
   assign sel         = addr[A_W-1 -: 4];
   assign unused_bits = ^{addr[A_W-5:3], wdata[D_W-1:10]};

   // KEY flops reset to 1 so a released key never looks like a press after reset
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sw_sync_q[i]  <= '0;
            key_sync_q[i] <= '1;
         end
         key_prev_q <= '1;
      end else begin
         sw_sync_q[0]  <= SW;
         key_sync_q[0] <= KEY;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sw_sync_q[i]  <= sw_sync_q[i-1];
            key_sync_q[i] <= key_sync_q[i-1];
         end
         key_prev_q <= key_s;
      end
   end

   always_comb begin
      state_d = state_q;
      rdata_d = '0;
      led_d   = led_q;
      hex_d   = hex_q;
      clr     = '0;
      if (state_q == IDLE && req) begin
         state_d = ACK;
         case (sel)
            4'h1: begin
               rdata_d = D_W'(led_q);
               if (wr) led_d = wdata[9:0];
            end
            4'h2: begin
               for (int i = 0; i < 6; i++) begin
                  if (addr[2:0] == 3'(i)) begin
                     rdata_d = D_W'(hex_q[i]);
                     if (wr) hex_d[i] = wdata[6:0];
                  end
               end
            end
            4'h3: rdata_d = D_W'(sw_s);
            4'h4: begin
               rdata_d = D_W'(cap_q);
               if (wr) clr = wdata[2:0];
            end
            default: ;
         endcase
      end else if (state_q == ACK) begin
         state_d = IDLE;
      end
      // A press on the clearing edge must survive, so set is applied after clear
      cap_d = (cap_q & ~clr) | press;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         rdata_q <= '0;
         led_q   <= '0;
         cap_q   <= '0;
         for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         led_q   <= led_d;
         cap_q   <= cap_d;
         hex_q   <= hex_d;
      end
   end

   assign ack   = (state_q == ACK);
   assign rdata = rdata_q;
   assign LEDR  = led_q;
   assign HEX0  = hex_q[0];
   assign HEX1  = hex_q[1];
   assign HEX2  = hex_q[2];
   assign HEX3  = hex_q[3];
   assign HEX4  = hex_q[4];
   assign HEX5  = hex_q[5];

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: table of bus accesses checked through an
// expected-rdata queue, plus hand sequences for sync, KEY capture and reset.
module tb_io_bus_responder;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        req;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ack;
   logic [15:0] rdata;
   logic [9:0]  SW;
   logic [2:0]  KEY;
   logic [9:0]  LEDR;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_q [$];

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] e;
   } vec_t;
   vec_t vecs [$];

   io_bus_responder #(.A_W(16), .D_W(16), .SYNC_STAGES(2)) dut (
      .Clock(Clock), .Resetn(Resetn), .req(req), .wr(wr), .addr(addr),
      .wdata(wdata), .ack(ack), .rdata(rdata), .SW(SW), .KEY(KEY),
      .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
      .HEX4(HEX4), .HEX5(HEX5)
   );

   always #10 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   // Called at a falling edge with the FSM idle; returns at a falling edge, idle again.
   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] e, input string name);
      int          k;
      logic        got;
      logic [15:0] ex;
      req   = 1'b1;
      wr    = w;
      addr  = a;
      wdata = d;
      exp_q.push_back(e);
      got = 1'b0;
      for (k = 0; k < 8; k++) begin
         @(negedge Clock);
         if (ack) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_ack_timeout: got no ack, wanted ack within 8 cycles", name);
         void'(exp_q.pop_front());
      end else begin
         check({name, "_latency"}, k, 0);
         ex = exp_q.pop_front();
         check({name, "_rdata"}, rdata, ex);
      end
      req = 1'b0;
      wr  = 1'b0;
      @(negedge Clock);
      check({name, "_ack_single"}, ack, 1'b0);
      check({name, "_rdata_idle"}, rdata, 16'h0000);
   endtask

   initial begin
      Resetn = 1'b0;
      req    = 1'b0;
      wr     = 1'b0;
      addr   = '0;
      wdata  = '0;
      SW     = '0;
      KEY    = 3'b111;

      vecs.push_back('{1'b0, 16'h1000, 16'h0000, 16'h02A5});
      vecs.push_back('{1'b1, 16'h2003, 16'h0040, 16'h007F});
      vecs.push_back('{1'b0, 16'h2003, 16'h0000, 16'h0040});
      vecs.push_back('{1'b0, 16'h2000, 16'h0000, 16'h007F});
      vecs.push_back('{1'b1, 16'h2007, 16'h1234, 16'h0000});
      vecs.push_back('{1'b0, 16'h2007, 16'h0000, 16'h0000});
      vecs.push_back('{1'b0, 16'h2005, 16'h0000, 16'h007F});
      vecs.push_back('{1'b1, 16'h2006, 16'h0000, 16'h0000});
      vecs.push_back('{1'b0, 16'h2006, 16'h0000, 16'h0000});
      vecs.push_back('{1'b1, 16'h9000, 16'hFFFF, 16'h0000});
      vecs.push_back('{1'b0, 16'h9000, 16'h0000, 16'h0000});
      vecs.push_back('{1'b0, 16'h1000, 16'h0000, 16'h02A5});
      vecs.push_back('{1'b1, 16'h1000, 16'hFFFF, 16'h02A5});
      vecs.push_back('{1'b0, 16'h1000, 16'h0000, 16'h03FF});
      vecs.push_back('{1'b0, 16'h2003, 16'h0000, 16'h0040});

      // Reset and hold
      repeat (3) @(negedge Clock);
      check("rst_ledr", LEDR, 10'h000);
      check("rst_hex0", HEX0, 7'h7F);
      check("rst_hex5", HEX5, 7'h7F);
      check("rst_ack", ack, 1'b0);
      check("rst_rdata", rdata, 16'h0000);
      Resetn = 1'b1;
      repeat (3) @(negedge Clock);
      check("hold_ledr", LEDR, 10'h000);
      check("hold_hex2", HEX2, 7'h7F);
      check("hold_ack", ack, 1'b0);
      check("hold_rdata", rdata, 16'h0000);

      // First LEDR write: pin and ack both appear in cycle N+1
      req = 1'b1; wr = 1'b1; addr = 16'h1000; wdata = 16'h02A5;
      check("ledr_before_edge", LEDR, 10'h000);
      @(negedge Clock);
      check("ledr_wr_ack", ack, 1'b1);
      check("ledr_wr_pin", LEDR, 10'h2A5);
      check("ledr_wr_rdata_old", rdata, 16'h0000);
      req = 1'b0; wr = 1'b0;
      @(negedge Clock);
      check("ledr_wr_ack_drop", ack, 1'b0);

      for (int i = 0; i < vecs.size(); i++)
         access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e, $sformatf("vec%0d", i));
      check("pins_ledr", LEDR, 10'h3FF);
      check("pins_hex0", HEX0, 7'h7F);
      check("pins_hex1", HEX1, 7'h7F);
      check("pins_hex2", HEX2, 7'h7F);
      check("pins_hex3", HEX3, 7'h40);
      check("pins_hex4", HEX4, 7'h7F);
      check("pins_hex5", HEX5, 7'h7F);

      // Switch synchronizer
      SW = 10'h3FF;
      repeat (3) @(negedge Clock);
      access(1'b0, 16'h3000, 16'h0000, 16'h03FF, "sw_rd");
      access(1'b1, 16'h3000, 16'h0000, 16'h03FF, "sw_wr");
      access(1'b0, 16'h3000, 16'h0000, 16'h03FF, "sw_rd_after_wr");
      SW = 10'h155;
      repeat (3) @(negedge Clock);
      access(1'b0, 16'h3000, 16'h0000, 16'h0155, "sw_rd155");
      SW = 10'h0AA;
      @(negedge Clock);
      access(1'b0, 16'h3000, 16'h0000, 16'h0155, "sw_stage_old");
      access(1'b0, 16'h3000, 16'h0000, 16'h00AA, "sw_stage_new");

      // KEY[1] pulse, read, clear
      KEY = 3'b101;
      repeat (5) @(negedge Clock);
      KEY = 3'b111;
      repeat (4) @(negedge Clock);
      access(1'b0, 16'h4000, 16'h0000, 16'h0002, "key1_rd");
      access(1'b1, 16'h4000, 16'h0002, 16'h0002, "key1_clr");
      access(1'b0, 16'h4000, 16'h0000, 16'h0000, "key1_rd_clr");

      // Held KEY[2] sets once; re-press sets again
      KEY = 3'b011;
      repeat (5) @(negedge Clock);
      access(1'b0, 16'h4000, 16'h0000, 16'h0004, "key2_rd");
      access(1'b1, 16'h4000, 16'h0004, 16'h0004, "key2_clr");
      access(1'b0, 16'h4000, 16'h0000, 16'h0000, "key2_held");
      KEY = 3'b111;
      repeat (4) @(negedge Clock);
      access(1'b0, 16'h4000, 16'h0000, 16'h0000, "key2_released");
      KEY = 3'b011;
      repeat (5) @(negedge Clock);
      access(1'b0, 16'h4000, 16'h0000, 16'h0004, "key2_repress");
      KEY = 3'b111;
      access(1'b1, 16'h4000, 16'h0004, 16'h0004, "key2_clr2");
      repeat (4) @(negedge Clock);
      access(1'b0, 16'h4000, 16'h0000, 16'h0000, "key2_rd_clr2");

      // KEY[0] press lands on the same edge as its clear: set wins
      KEY = 3'b110;
      @(negedge Clock);
      @(negedge Clock);
      access(1'b1, 16'h4000, 16'h0001, 16'h0000, "key0_clr_race");
      access(1'b0, 16'h4000, 16'h0000, 16'h0001, "key0_set_wins");
      KEY = 3'b111;
      access(1'b1, 16'h4000, 16'h0001, 16'h0001, "key0_clr");
      access(1'b0, 16'h4000, 16'h0000, 16'h0000, "key0_rd_clr");

      // req held high on an unmapped read
      req = 1'b1; wr = 1'b0; addr = 16'h9000;
      begin
         logic prev_ack;
         prev_ack = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            check($sformatf("burst_ack%0d", i), ack, (i % 2 == 0));
            check($sformatf("burst_rdata%0d", i), rdata, 16'h0000);
            check($sformatf("burst_no_double%0d", i), prev_ack & ack, 1'b0);
            prev_ack = ack;
         end
      end
      req = 1'b0;
      @(negedge Clock);
      check("burst_end_ack", ack, 1'b0);

      // Reset wins the IDLE->ACK edge of a write
      req = 1'b1; wr = 1'b1; addr = 16'h1000; wdata = 16'h0123;
      Resetn = 1'b0;
      @(negedge Clock);
      check("rstmid_ack", ack, 1'b0);
      check("rstmid_ledr", LEDR, 10'h000);
      check("rstmid_hex3", HEX3, 7'h7F);
      @(negedge Clock);
      req = 1'b0; wr = 1'b0;
      Resetn = 1'b1;
      @(negedge Clock);
      check("rstmid_after_ack", ack, 1'b0);
      check("rstmid_after_ledr", LEDR, 10'h000);
      @(negedge Clock);
      check("rstmid_after_ack2", ack, 1'b0);
      access(1'b0, 16'h1000, 16'h0000, 16'h0000, "rstmid_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
